// File: rtl/rst_seq_pkg.sv
// Shared types for the reset sequencer: FSM state encoding and reset-cause codes.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        HOLD      = 2'd0,
        WAIT_LOCK = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } state_e;

    localparam logic [1:0] CAUSE_POR      = 2'd0;
    localparam logic [1:0] CAUSE_TRIGGER  = 2'd1;
    localparam logic [1:0] CAUSE_LOCKLOSS = 2'd2;

endpackage

// File: rtl/sync_ff.sv
// Multi-stage synchroniser with synchronous active-low clear; q_o is d_i delayed by STAGES edges.
module sync_ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // Shift register clocked by clk_i, cleared while rst_ni is low
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/rst_sequencer.sv
// Reset sequencer: holds all channel resets low, waits for PLL lock, then releases
// channels in index order with per-channel delays; re-sequences on trigger or lock loss.
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int unsigned               N_CHAN      = 2,
    parameter int unsigned               CNT_W       = 20,
    parameter int unsigned               HOLD_CYCLES = 128,
    parameter logic [N_CHAN*CNT_W-1:0]   REL_DELAYS  = {20'hFFFFF, 20'd128},
    parameter int unsigned               LOCK_STAGES = 2
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              pll_locked,
    input  logic              trigger_reset,
    output logic [N_CHAN-1:0] rst_n_out,
    output logic              seq_done,
    output logic [1:0]        rst_cause
);

    localparam int unsigned       IDX_W     = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;
    localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_CHAN - 1);

    if ((N_CHAN < 1) || (N_CHAN > 8)) begin : g_bad_nchan
        $error("rst_sequencer: N_CHAN must be in 1..8");
    end
    if ((HOLD_CYCLES < 1) || (((HOLD_CYCLES - 1) >> CNT_W) != 32'd0)) begin : g_bad_hold
        $error("rst_sequencer: HOLD_CYCLES must be >=1 and HOLD_CYCLES-1 must fit CNT_W");
    end
    if (LOCK_STAGES < 2) begin : g_bad_stages
        $error("rst_sequencer: LOCK_STAGES must be >= 2");
    end

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [N_CHAN-1:0]  rst_n_q, rst_n_d;
    logic               seq_done_q, seq_done_d;
    logic [1:0]         cause_q, cause_d;
    logic               locked_s;
    logic [CNT_W-1:0]   delay_s;

    sync_ff #(
        .STAGES (LOCK_STAGES)
    ) u_lock_sync (
        .clk_i  (sys_clk),
        .rst_ni (sys_rst_n),
        .d_i    (pll_locked),
        .q_o    (locked_s)
    );

    // Release delay of the channel currently being sequenced
    assign delay_s = REL_DELAYS[32'(idx_q) * CNT_W +: CNT_W];

    // Next-state logic: aborts take priority over the normal sequence, trigger over lock loss
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        rst_n_d    = rst_n_q;
        seq_done_d = seq_done_q;
        cause_d    = cause_q;
        if (trigger_reset) begin
            state_d    = HOLD;
            cnt_d      = '0;
            idx_d      = '0;
            rst_n_d    = '0;
            seq_done_d = 1'b0;
            cause_d    = CAUSE_TRIGGER;
        end else if (!locked_s && ((state_q == RELEASE) || (state_q == RUN))) begin
            state_d    = HOLD;
            cnt_d      = '0;
            idx_d      = '0;
            rst_n_d    = '0;
            seq_done_d = 1'b0;
            cause_d    = CAUSE_LOCKLOSS;
        end else begin
            case (state_q)
                HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                WAIT_LOCK: begin
                    if (locked_s) begin
                        state_d = RELEASE;
                        cnt_d   = '0;
                        idx_d   = '0;
                    end else begin
                        state_d = WAIT_LOCK;
                    end
                end
                RELEASE: begin
                    if (cnt_q == delay_s) begin
                        rst_n_d[idx_q] = 1'b1;
                        cnt_d          = '0;
                        if (idx_q == IDX_LAST) begin
                            state_d    = RUN;
                            seq_done_d = 1'b1;
                            idx_d      = '0;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                RUN: begin
                    rst_n_d    = {N_CHAN{1'b1}};
                    seq_done_d = 1'b1;
                end
                default: begin
                    state_d    = HOLD;
                    cnt_d      = '0;
                    idx_d      = '0;
                    rst_n_d    = '0;
                    seq_done_d = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q    <= HOLD;
            cnt_q      <= '0;
            idx_q      <= '0;
            rst_n_q    <= '0;
            seq_done_q <= 1'b0;
            cause_q    <= CAUSE_POR;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            rst_n_q    <= rst_n_d;
            seq_done_q <= seq_done_d;
            cause_q    <= cause_d;
        end
    end

    assign rst_n_out = rst_n_q;
    assign seq_done  = seq_done_q;
    assign rst_cause = cause_q;

endmodule
